pipe_stage_ctrl: RTL and testbench
==================================

PIPE_STAGE_CTRL -- requirements
Module: pipe_stage_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of enable-gated register stages sequenced (legal range 1..32).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(DEPTH+1): occupancy counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port flush, input, 1 bit: discard all in-flight entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream offers a word.
REQ-007 The block SHALL have port in_ready, output, 1 bit: stage 0 accepts this cycle.
REQ-008 The block SHALL have port out_valid, output, 1 bit: last stage holds a valid word.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-010 The block SHALL have port stage_en, output, DEPTH bits: per-stage load enable driving the datapath registers; bit 0 is the input side.
REQ-011 The block SHALL have port stage_vld, output, DEPTH bits: per-stage valid flags.
REQ-012 The block SHALL have port occupancy, output, CNT_W bits: count of valid stages.
REQ-013 The block SHALL have port empty, output, 1 bit: occupancy == 0.
REQ-014 The block SHALL have port full, output, 1 bit: occupancy == DEPTH.

Function
REQ-015 The block SHALL define fire_in = in_valid & in_ready and fire_out = out_valid & out_ready.
REQ-016 The last stage SHALL assert stage_en[DEPTH-1] = ~stage_vld[DEPTH-1] | out_ready.
REQ-017 Each stage i < DEPTH-1 SHALL assert stage_en[i] = ~stage_vld[i] | stage_en[i+1], so bubbles collapse and a stall holds only stages behind a valid blocked stage.
REQ-018 When flush = 0, in_ready SHALL equal stage_en[0].
REQ-019 When flush = 0, out_valid SHALL equal stage_vld[DEPTH-1].
REQ-020 On a clock edge with stage_en[i] = 1, stage_vld[i] SHALL load stage_vld[i-1] (in_valid for i = 0); otherwise it SHALL hold.
REQ-021 Latency SHALL be DEPTH cycles: a word accepted at edge N into an empty pipe with out_ready = 1 SHALL be presented with out_valid = 1 in the cycle after edge N+DEPTH-1.
REQ-022 Sustained throughput SHALL be one word per cycle when out_ready stays 1.
REQ-023 Occupancy SHALL update as +1 on fire_in only, -1 on fire_out only, and unchanged when both or neither occur.
REQ-024 Occupancy SHALL never exceed DEPTH nor go below 0.
REQ-025 A full pipe with out_ready = 1 SHALL accept a new word in the same cycle (in_ready = 1) and stay full.
REQ-026 A full pipe with out_ready = 0 SHALL force in_ready = 0 and stage_en = 0.
REQ-027 flush = 1 SHALL force in_ready = 0, out_valid = 0 and stage_en = all-ones in that cycle.
REQ-028 flush = 1 SHALL clear stage_vld to 0 and occupancy to 0 at the next edge, overriding any simultaneous fire.
REQ-029 stage_en, in_ready and out_valid SHALL be combinational from state, flush and out_ready.
REQ-030 stage_vld, occupancy, empty and full SHALL be registered or derived only from registered state.

Reset
REQ-031 While rst = 1 at a clock edge, the block SHALL clear stage_vld and occupancy to 0, which sets empty = 1 and full = 0.
REQ-032 In the reset cycle, outputs SHALL be out_valid = 0, and in_ready = 1 with stage_en = all-ones (pipe empty), unless flush = 1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight words with no fire_out afterwards.
REQ-034 rst SHALL have priority over flush and over handshakes.

Verification
REQ-035 The bench SHALL check: DEPTH=4, reset, then in_valid = 1 for 1 cycle with out_ready = 1 -> out_valid pulses exactly once, 4 cycles after acceptance; occupancy goes 1,1,1,1,0.
REQ-036 The bench SHALL check: continuous in_valid with out_ready = 0 -> in_ready drops after 4 accepts, full = 1, occupancy = 4, stage_en = 0000.
REQ-037 The bench SHALL check: full pipe, out_ready = 1 and in_valid = 1 together -> one accept and one output per cycle, occupancy stays 4.
REQ-038 The bench SHALL check: a single bubble at stage 1 with stage 3 stalled -> stage_en = 0011, and stage_vld changes 1101 -> 1110 after the edge with in_valid = 0.
REQ-039 The bench SHALL check: flush asserted with occupancy = 3 plus simultaneous in_valid -> no accept, out_valid = 0 that cycle, occupancy = 0 and empty = 1 next cycle.
REQ-040 The bench SHALL check: rst pulsed mid-stream at occupancy = 2 -> stage_vld = 0000 and no out_valid until new input.

Source files
------------

// File: rtl/pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_ctrl
// Brief    : Valid/enable sequencer for a DEPTH-stage elastic register pipe.
// Revision : 1.0
// ============================================================================
module pipe_stage_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEPTH-1:0] stage_en,
    output logic [DEPTH-1:0] stage_vld,
    output logic [CNT_W-1:0] occupancy,
    output logic             empty,
    output logic             full
);

    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [DEPTH-1:0] stage_vld_q;
    logic [DEPTH-1:0] stage_vld_d;
    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;

    logic             w_fire_in;
    logic             w_fire_out;
    logic             w_blocked;

    // A stage is held only when it and every stage downstream of it are
    // valid and the sink is not taking a word; bubbles elsewhere collapse.
    always_comb begin
        w_blocked = ~out_ready;
        stage_en  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_blocked   = w_blocked & stage_vld_q[i];
            stage_en[i] = ~w_blocked;
        end
        in_ready  = stage_en[0];
        out_valid = stage_vld_q[DEPTH-1];
        if (rst || flush) begin
            stage_en  = '1;
            in_ready  = ~flush;
            out_valid = 1'b0;
        end
    end

    assign w_fire_in  = in_valid & in_ready;
    assign w_fire_out = out_valid & out_ready;

    always_comb begin
        stage_vld_d    = stage_vld_q;
        stage_vld_d[0] = stage_en[0] ? in_valid : stage_vld_q[0];
        for (int i = 1; i < DEPTH; i++) begin
            if (stage_en[i]) begin
                stage_vld_d[i] = stage_vld_q[i-1];
            end
        end

        occ_d = occ_q;
        if (w_fire_in && !w_fire_out) begin
            occ_d = occ_q + C_ONE;
        end else if (w_fire_out && !w_fire_in) begin
            occ_d = occ_q - C_ONE;
        end

        if (flush) begin
            stage_vld_d = '0;
            occ_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld_q <= '0;
            occ_q       <= '0;
        end else begin
            stage_vld_q <= stage_vld_d;
            occ_q       <= occ_d;
        end
    end

    assign stage_vld = stage_vld_q;
    assign occupancy = occ_q;
    assign empty     = (occ_q == '0);
    assign full      = (occ_q == C_DEPTH);

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_ctrl
// Brief    : Directed self-checking bench for pipe_stage_ctrl (DEPTH = 4).
// Revision : 1.0
// ============================================================================
module tb_pipe_stage_ctrl;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [DEPTH-1:0] stage_en;
    logic [DEPTH-1:0] stage_vld;
    logic [CNT_W-1:0] occupancy;
    logic             empty;
    logic             full;

    int n_total = 0;
    int n_bad   = 0;

    pipe_stage_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stage_en  (stage_en),
        .stage_vld (stage_vld),
        .occupancy (occupancy),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] exp_ov [5];
    logic [2:0] exp_oc [5];
    int         pulses;
    int         waited;

    initial begin
        exp_ov = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_oc = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stage_en", stage_en, 4'hf);
        chk("rst_out_valid", out_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_vld", stage_vld, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);

        // Single word through an empty pipe.
        in_valid = 1'b1;
        #1;
        chk("single_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("single_ov%0d", k), out_valid, exp_ov[k]);
            chk($sformatf("single_occ%0d", k), occupancy, exp_oc[k]);
            if (out_valid) pulses++;
            if (k < 4) tick();
        end
        chk("single_pulses", pulses, 1);

        // Fill with the sink stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("fill_in_ready%0d", k), in_ready, 1);
            tick();
        end
        #1;
        chk("fill_in_ready_drop", in_ready, 0);
        chk("fill_full", full, 1);
        chk("fill_occ", occupancy, 4);
        chk("fill_stage_en", stage_en, 4'h0);
        chk("fill_vld", stage_vld, 4'hf);
        tick();
        chk("fill_hold_occ", occupancy, 4);

        // Full pipe streaming: one in, one out per cycle.
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stream_in_ready%0d", k), in_ready, 1);
            chk($sformatf("stream_out_valid%0d", k), out_valid, 1);
            chk($sformatf("stream_en%0d", k), stage_en, 4'hf);
            tick();
            chk($sformatf("stream_occ%0d", k), occupancy, 4);
            chk($sformatf("stream_full%0d", k), full, 1);
        end

        // Drain via flush, then build 1101 with the sink stalled.
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        chk("drain_empty", empty, 1);
        in_valid = 1'b1; tick(); chk("bub_vld_a", stage_vld, 4'b0001);
        in_valid = 1'b1; tick(); chk("bub_vld_b", stage_vld, 4'b0011);
        in_valid = 1'b0; tick(); chk("bub_vld_c", stage_vld, 4'b0110);
        in_valid = 1'b1; tick(); chk("bub_vld_d", stage_vld, 4'b1101);
        in_valid = 1'b0;
        #1;
        chk("bub_stage_en", stage_en, 4'b0011);
        tick();
        chk("bub_vld_e", stage_vld, 4'b1110);
        chk("bub_occ", occupancy, 3);

        // Flush with a simultaneous offer.
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_stage_en", stage_en, 4'hf);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_occ", occupancy, 0);
        chk("flush_empty", empty, 1);
        chk("flush_vld", stage_vld, 0);

        // Reset mid-stream at occupancy 2.
        out_ready = 1'b0; in_valid = 1'b1;
        tick(); tick();
        chk("mid_occ", occupancy, 2);
        in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_vld", stage_vld, 0);
        chk("mid_occ0", occupancy, 0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (out_valid) pulses++;
            tick();
        end
        chk("mid_no_out", pulses, 0);

        // New word after reset still arrives DEPTH cycles later.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        waited = 1;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        chk("post_rst_latency", waited, 4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
